// File: rtl/serializer_n1_mlane.sv
// serializer_n1_mlane: single-clock multi-lane N:1 parallel-to-serial transmitter.
// Words enter a one-word holding buffer through a valid/ready handshake.
// Each lane then shifts one bit per clk_i onto a complementary output pair.
// All lanes share one bit counter and one handshake.
// Optional build macro: SERIALIZER_IDLE_WORD_EN. When it is defined, an underrun
// loads IDLE_WORD on every lane; otherwise an underrun loads all-zero.
//
// Handshake: a word is accepted on a rising clk_i edge where p_valid_i and
// p_ready_o are both high. p_ready_o is high only while the block is running
// and the holding buffer is empty. p_data_i is ignored on every other edge.
module serializer_n1_mlane #(
  parameter int               DATA_W    = 10,
  parameter int               LANES     = 1,
  parameter int               MSB_FIRST = 0,
  parameter logic [DATA_W-1:0] IDLE_WORD = {DATA_W{1'b0}}
) (
  input  logic                    clk_i,
  input  logic                    a_rst_n_i,
  input  logic                    p_valid_i,
  output logic                    p_ready_o,
  input  logic [LANES*DATA_W-1:0] p_data_i,
  output logic [LANES-1:0]        s_data_p_o,
  output logic [LANES-1:0]        s_data_n_o,
  output logic                    word_start_o,
  output logic                    underrun_o
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SERIALIZER_IDLE_WORD_EN
  localparam logic [DATA_W-1:0] FILL_WORD = IDLE_WORD;
`else
  // IDLE_WORD has no effect in this build; the fill word is forced to zero.
  localparam logic [DATA_W-1:0] FILL_WORD = IDLE_WORD & {DATA_W{1'b0}};
`endif

  logic                           r_run;
  logic [CNT_W-1:0]               r_bit_cnt;
  logic [LANES*DATA_W-1:0]        r_hold;
  logic                           r_hold_full;
  logic [LANES-1:0][DATA_W-1:0]   r_shift;
  logic                           r_idle;
  logic [LANES-1:0]               r_s_p;
  logic [LANES-1:0]               r_s_n;
  logic                           r_word_start;
  logic                           r_underrun;

  logic                           w_ready;
  logic                           w_accept;
  logic                           w_last;
  logic [LANES-1:0]               w_out_bit;

  assign w_ready  = r_run & ~r_hold_full;
  assign w_accept = p_valid_i & w_ready;
  assign w_last   = (r_bit_cnt == LAST_BIT);

  // Select the output-end bit of each lane's shift register.
  always_comb begin
    w_out_bit = '0;
    for (int k = 0; k < LANES; k++) begin
      if (MSB_FIRST != 0) w_out_bit[k] = r_shift[k][DATA_W-1];
      else                w_out_bit[k] = r_shift[k][0];
    end
  end

  // Bit counter, hold buffer, shift registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!a_rst_n_i) begin
      r_run        <= 1'b0;
      r_bit_cnt    <= LAST_BIT;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_idle       <= 1'b0;
      for (int k = 0; k < LANES; k++) r_shift[k] <= FILL_WORD;
      r_s_p        <= '0;
      r_s_n        <= '1;
      r_word_start <= 1'b0;
      r_underrun   <= 1'b0;
    end else if (!r_run) begin
      // First edge out of reset only arms the block.
      r_run <= 1'b1;
    end else begin
      r_s_p        <= w_out_bit;
      r_s_n        <= ~w_out_bit;
      r_word_start <= (r_bit_cnt == '0);
      r_underrun   <= (r_bit_cnt == '0) & r_idle;

      if (w_last) begin
        r_bit_cnt <= '0;
        if (r_hold_full) begin
          for (int k = 0; k < LANES; k++) r_shift[k] <= r_hold[k*DATA_W +: DATA_W];
          r_idle <= 1'b0;
        end else begin
          for (int k = 0; k < LANES; k++) r_shift[k] <= FILL_WORD;
          r_idle <= 1'b1;
        end
        // The hold empties into the shifter unless refilled on this same edge.
        r_hold_full <= w_accept;
      end else begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        for (int k = 0; k < LANES; k++) begin
          if (MSB_FIRST != 0) r_shift[k] <= r_shift[k] << 1;
          else                r_shift[k] <= r_shift[k] >> 1;
        end
        if (w_accept) r_hold_full <= 1'b1;
      end

      if (w_accept) r_hold <= p_data_i;
    end
  end

  assign p_ready_o    = w_ready;
  assign s_data_p_o   = r_s_p;
  assign s_data_n_o   = r_s_n;
  assign word_start_o = r_word_start;
  assign underrun_o   = r_underrun;

endmodule

// File: tb/tb_serializer_n1_mlane.sv
// tb_serializer_n1_mlane: two serializer instances (LSB-first and MSB-first) share
// the same stimulus. A reference model predicts every output bit. It treats
// the link as a bit stream: whenever the stream runs dry, the next word is
// appended, taken from the pending slot if one is waiting, otherwise an idle word.
module tb_serializer_n1_mlane;

  localparam int W  = 10;
  localparam int L  = 2;
  localparam int EW = 2 + 2*L;
  localparam logic [W-1:0] IDLE_W = 10'h17C;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           valid;
  logic [L*W-1:0] data;

  logic           rdy_a, rdy_b, ws_a, ws_b, ur_a, ur_b;
  logic [L-1:0]   p_a, n_a, p_b, n_b;

  serializer_n1_mlane #(.DATA_W(W), .LANES(L), .MSB_FIRST(0), .IDLE_WORD(IDLE_W)) dut_a (
    .clk_i(clk), .a_rst_n_i(rst_n), .p_valid_i(valid), .p_ready_o(rdy_a),
    .p_data_i(data), .s_data_p_o(p_a), .s_data_n_o(n_a),
    .word_start_o(ws_a), .underrun_o(ur_a)
  );

  serializer_n1_mlane #(.DATA_W(W), .LANES(L), .MSB_FIRST(1), .IDLE_WORD(IDLE_W)) dut_b (
    .clk_i(clk), .a_rst_n_i(rst_n), .p_valid_i(valid), .p_ready_o(rdy_b),
    .p_data_i(data), .s_data_p_o(p_b), .s_data_n_o(n_b),
    .word_start_o(ws_b), .underrun_o(ur_b)
  );

  // ---------------- scoreboard / reference model ----------------
  // Entry layout: [L-1:0] LSB-first lane bits, [2L-1:L] MSB-first lane bits,
  // [2L] word start, [2L+1] underrun.
  int tests = 0;
  int fails = 0;

  logic [EW-1:0]  exp_q[$];
  logic           m_run  = 1'b0;
  logic           m_pend = 1'b0;
  logic           m_acc  = 1'b0;
  logic [L*W-1:0] m_hold = '0;
  logic [EW-1:0]  m_out  = '0;
  logic [W-1:0]   m_idle_word;

`ifdef SERIALIZER_IDLE_WORD_EN
  initial m_idle_word = IDLE_W;
`else
  initial m_idle_word = '0;
`endif

  task automatic load_word(input logic [L*W-1:0] w, input logic idle);
    logic [EW-1:0] e;
    for (int b = 0; b < W; b++) begin
      e = '0;
      for (int k = 0; k < L; k++) begin
        e[k]     = w[k*W + b];
        e[L + k] = w[k*W + (W-1-b)];
      end
      e[2*L]     = (b == 0);
      e[2*L + 1] = idle && (b == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic model_edge(input logic rst, input logic v, input logic [L*W-1:0] d);
    logic was_ready;
    m_acc = 1'b0;
    if (!rst) begin
      exp_q.delete();
      m_run  = 1'b0;
      m_pend = 1'b0;
      m_out  = '0;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else begin
      was_ready = !m_pend;
      if (exp_q.size() != 0) begin
        m_out = exp_q.pop_front();
      end else begin
        // Very first load after reset: the output shows the untouched fill word's end bit.
        m_out = '0;
        for (int k = 0; k < L; k++) begin
          m_out[k]     = m_idle_word[0];
          m_out[L + k] = m_idle_word[W-1];
        end
      end
      if (exp_q.size() == 0) begin
        if (m_pend) begin
          load_word(m_hold, 1'b0);
          m_pend = 1'b0;
        end else begin
          load_word({L{m_idle_word}}, 1'b1);
        end
      end
      if (v && was_ready) begin
        m_hold = d;
        m_pend = 1'b1;
        m_acc  = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [L-1:0] ea, eb;
    logic         er;
    ea = m_out[L-1:0];
    eb = m_out[2*L-1:L];
    er = m_run && !m_pend;
    chk("lane_lsb", 8'({p_a, n_a, ws_a, ur_a, rdy_a}), 8'({ea, ~ea, m_out[2*L], m_out[2*L+1], er}));
    chk("lane_msb", 8'({p_b, n_b, ws_b, ur_b, rdy_b}), 8'({eb, ~eb, m_out[2*L], m_out[2*L+1], er}));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic rst, input logic v, input logic [L*W-1:0] d);
    rst_n = rst;
    valid = v;
    data  = d;
    @(posedge clk);
    model_edge(rst, v, d);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, (L*W)'({$urandom(), $urandom()}));
  endtask

  // Hold valid with fixed data until the model says the word was taken.
  task automatic send(input logic [L*W-1:0] d);
    int budget;
    budget = 4*W;
    do begin
      step(1'b1, 1'b1, d);
      budget--;
    end while (!m_acc && budget > 0);
    if (!m_acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout at %0t: got=no_accept expected=accept", $time);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;

    // Reset state, then pure underrun (idle words with underrun pulses).
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    idle_cycles(3*W + 2);

    // Single word, lane0 = 10'h201.
    send({10'h155, 10'h201});
    idle_cycles(2*W + 3);

    // Back-to-back words with valid held high.
    send({10'h0F0, 10'h201});
    send({10'h2AA, 10'h303});
    idle_cycles(3*W);

    // Lanes {3FF, 001}: bit alignment across lanes.
    send({10'h3FF, 10'h001});
    idle_cycles(2*W + 2);

    // Reset in mid-word while the hold buffer is full.
    send({10'h111, 10'h222});
    send({10'h333, 10'h3CC});
    idle_cycles(4);
    step(1'b0, 1'b0, '0);
    idle_cycles(3*W);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0)
        step(1'b0, 1'b0, '0);
      else
        step(1'b1, ($urandom_range(0, 3) != 0), (L*W)'({$urandom(), $urandom()}));
    end
    idle_cycles(2*W);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
